// File: rtl/s2_kes_sched.sv
// Sequencer between the syndrome stage and the DCME key-equation solver:
// 2-deep syndrome FIFO, zero-syndrome bypass, solver launch/qualify, watchdog.
module s2_kes_sched #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             syn_valid,
    output logic             syn_ready,
    input  logic [7:0]       syn0,
    input  logic [7:0]       syn1,
    input  logic [7:0]       syn2,
    input  logic [7:0]       syn3,
    input  logic [TAG_W-1:0] syn_tag,
    output logic             kes_ena,
    output logic [7:0]       kes_syn0,
    output logic [7:0]       kes_syn1,
    output logic [7:0]       kes_syn2,
    output logic [7:0]       kes_syn3,
    input  logic             kes_done,
    input  logic [7:0]       kes_lambda0,
    input  logic [7:0]       kes_lambda1,
    input  logic [7:0]       kes_lambda2,
    input  logic [7:0]       kes_omega0,
    input  logic [7:0]       kes_omega1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_lambda0,
    output logic [7:0]       out_lambda1,
    output logic [7:0]       out_lambda2,
    output logic [7:0]       out_omega0,
    output logic [7:0]       out_omega1,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err_free,
    output logic             out_fail,
    output logic             busy
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [7:0]       s3;
        logic [7:0]       s2;
        logic [7:0]       s1;
        logic [7:0]       s0;
    } entry_t;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        LAUNCH = 5'b00010,
        ARM    = 5'b00100,
        WAIT   = 5'b01000,
        OUT    = 5'b10000
    } state_t;

    state_t           state;
    entry_t           fifo [2];
    entry_t           head;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             full;
    logic             empty;
    logic             head_zero;
    logic             push;
    logic             pop;
    logic [WD_W-1:0]  wdog;
    logic [TAG_W-1:0] tag_q;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign syn_ready = !full;
    assign head      = fifo[rd_ptr];
    assign head_zero = ({head.s3, head.s2, head.s1, head.s0} == 32'd0);
    assign push      = syn_valid && !full;
    assign pop       = (state == LAUNCH) || ((state == IDLE) && !empty && head_zero);

    assign kes_syn0 = head.s0;
    assign kes_syn1 = head.s1;
    assign kes_syn2 = head.s2;
    assign kes_syn3 = head.s3;
    assign busy     = (state != IDLE) || !empty;

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= '{tag: syn_tag, s3: syn3, s2: syn2, s1: syn1, s0: syn0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            kes_ena      <= 1'b0;
            out_valid    <= 1'b0;
            wdog         <= '0;
            tag_q        <= '0;
            out_lambda0  <= '0;
            out_lambda1  <= '0;
            out_lambda2  <= '0;
            out_omega0   <= '0;
            out_omega1   <= '0;
            out_tag      <= '0;
            out_err_free <= 1'b0;
            out_fail     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_zero) begin
                            out_lambda0  <= '0;
                            out_lambda1  <= '0;
                            out_lambda2  <= '0;
                            out_omega0   <= '0;
                            out_omega1   <= '0;
                            out_tag      <= head.tag;
                            out_err_free <= 1'b1;
                            out_fail     <= 1'b0;
                            out_valid    <= 1'b1;
                            state        <= OUT;
                        end else begin
                            kes_ena <= 1'b1;
                            state   <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    tag_q   <= head.tag;
                    kes_ena <= 1'b0;
                    state   <= ARM;
                end
                // kes_done still reflects the previous solve here.
                ARM: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (kes_done) begin
                        out_lambda0  <= kes_lambda0;
                        out_lambda1  <= kes_lambda1;
                        out_lambda2  <= kes_lambda2;
                        out_omega0   <= kes_omega0;
                        out_omega1   <= kes_omega1;
                        out_tag      <= tag_q;
                        out_err_free <= 1'b0;
                        out_fail     <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= OUT;
                    end else if (wdog == WD_W'(TIMEOUT)) begin
                        out_lambda0  <= '0;
                        out_lambda1  <= '0;
                        out_lambda2  <= '0;
                        out_omega0   <= '0;
                        out_omega1   <= '0;
                        out_tag      <= tag_q;
                        out_err_free <= 1'b0;
                        out_fail     <= 1'b1;
                        out_valid    <= 1'b1;
                        state        <= OUT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    kes_ena   <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_s2_kes_sched.sv
// Bench for s2_kes_sched: directed table, hand sequences, randomized traffic
// against a transaction-level result model and a behavioural solver.
module tb_s2_kes_sched;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             syn_valid = 1'b0;
    logic             syn_ready;
    logic [7:0]       syn0 = '0, syn1 = '0, syn2 = '0, syn3 = '0;
    logic [TAG_W-1:0] syn_tag = '0;
    logic             kes_ena;
    logic [7:0]       kes_syn0, kes_syn1, kes_syn2, kes_syn3;
    logic             kes_done = 1'b1;
    logic [7:0]       kes_lambda0 = '0, kes_lambda1 = '0, kes_lambda2 = '0;
    logic [7:0]       kes_omega0 = '0, kes_omega1 = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1;
    logic [TAG_W-1:0] out_tag;
    logic             out_err_free, out_fail, busy;

    always #5 clk = ~clk;

    s2_kes_sched #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .syn_valid(syn_valid), .syn_ready(syn_ready),
        .syn0(syn0), .syn1(syn1), .syn2(syn2), .syn3(syn3), .syn_tag(syn_tag),
        .kes_ena(kes_ena),
        .kes_syn0(kes_syn0), .kes_syn1(kes_syn1), .kes_syn2(kes_syn2), .kes_syn3(kes_syn3),
        .kes_done(kes_done),
        .kes_lambda0(kes_lambda0), .kes_lambda1(kes_lambda1), .kes_lambda2(kes_lambda2),
        .kes_omega0(kes_omega0), .kes_omega1(kes_omega1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lambda0(out_lambda0), .out_lambda1(out_lambda1), .out_lambda2(out_lambda2),
        .out_omega0(out_omega0), .out_omega1(out_omega1),
        .out_tag(out_tag), .out_err_free(out_err_free), .out_fail(out_fail),
        .busy(busy)
    );

    // lat = cycles from launch to kes_done; 0 means the solver never answers
    typedef struct packed {
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] lat;
        logic [7:0] l0, l1, l2, o0, o1;
    } resp_t;

    typedef struct packed {
        logic [7:0]       l0, l1, l2, o0, o1;
        logic [TAG_W-1:0] tag;
        logic             ef, fl;
    } res_t;

    typedef struct packed {
        resp_t            r;
        logic [TAG_W-1:0] tag;
        res_t             e;
        logic [7:0]       k;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    ena_cnt = 0;
    resp_t nxt_resp = '0;
    res_t  nxt_exp = '0;
    logic  rand_rdy = 1'b0;
    res_t  exp_q[$];
    resp_t resp_q[$];
    resp_t cur = '0;
    int    sol_cnt = 0;
    logic  sol_active = 1'b0;
    logic  prev_ena = 1'b0;
    logic  stalled = 1'b0;
    res_t  snap = '0;
    res_t  got;
    vec_t  vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic res_t model(input resp_t r, input logic [TAG_W-1:0] tag);
        res_t m = '0;
        m.tag = tag;
        if (r.s0 == 0 && r.s1 == 0 && r.s2 == 0 && r.s3 == 0) m.ef = 1'b1;
        else if (r.lat == 0) m.fl = 1'b1;
        else begin
            m.l0 = r.l0; m.l1 = r.l1; m.l2 = r.l2; m.o0 = r.o0; m.o1 = r.o1;
        end
        return m;
    endfunction

    function automatic resp_t mkr(input logic [7:0] s0, s1, s2, s3, lat, l0, l1, l2, o0, o1);
        resp_t r;
        r.s0 = s0; r.s1 = s1; r.s2 = s2; r.s3 = s3; r.lat = lat;
        r.l0 = l0; r.l1 = l1; r.l2 = l2; r.o0 = o0; r.o1 = o1;
        return r;
    endfunction

    function automatic vec_t mkv(input resp_t r, input logic [TAG_W-1:0] tag,
                                 input logic [7:0] el0, el1, el2, eo0, eo1,
                                 input logic ef, fl, input logic [7:0] k);
        vec_t v;
        v.r = r; v.tag = tag; v.k = k;
        v.e.l0 = el0; v.e.l1 = el1; v.e.l2 = el2; v.e.o0 = eo0; v.e.o1 = eo1;
        v.e.tag = tag; v.e.ef = ef; v.e.fl = fl;
        return v;
    endfunction

    // Acceptance bookkeeping, solver behaviour and output scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            resp_q.delete();
            sol_active = 1'b0;
            stalled    = 1'b0;
            prev_ena   = 1'b0;
        end else begin
            if (syn_valid && syn_ready) begin
                exp_q.push_back(nxt_exp);
                if ({syn0, syn1, syn2, syn3} != 32'd0) resp_q.push_back(nxt_resp);
            end
            if (kes_ena) begin
                ena_cnt++;
                chk("kes_ena_single", 64'(prev_ena), 64'(0));
                chk("launch_expected", 64'(resp_q.size() != 0), 64'(1));
                if (resp_q.size() != 0) begin
                    cur = resp_q.pop_front();
                    chk("kes_syn", 64'({kes_syn0, kes_syn1, kes_syn2, kes_syn3}),
                        64'({cur.s0, cur.s1, cur.s2, cur.s3}));
                    sol_cnt    = 0;
                    sol_active = 1'b1;
                end
            end else if (sol_active) begin
                sol_cnt++;
                if (sol_cnt == 1) kes_done = 1'b0;
                if (cur.lat != 0 && sol_cnt == int'(cur.lat)) begin
                    kes_done    = 1'b1;
                    kes_lambda0 = cur.l0; kes_lambda1 = cur.l1; kes_lambda2 = cur.l2;
                    kes_omega0  = cur.o0; kes_omega1  = cur.o1;
                end
            end
            prev_ena = kes_ena;
            got = '{l0: out_lambda0, l1: out_lambda1, l2: out_lambda2, o0: out_omega0,
                    o1: out_omega1, tag: out_tag, ef: out_err_free, fl: out_fail};
            if (stalled) begin
                chk("stall_valid_hold", 64'(out_valid), 64'(1));
                chk("stall_data_hold", 64'(got), 64'(snap));
            end
            stalled = out_valid && !out_ready;
            if (stalled) snap = got;
            if (out_valid && out_ready) begin
                chk("output_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) chk("result", 64'(got), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic drive(input resp_t r, input logic [TAG_W-1:0] tag, input res_t e);
        nxt_resp = r;
        nxt_exp  = e;
        syn0 = r.s0; syn1 = r.s1; syn2 = r.s2; syn3 = r.s3; syn_tag = tag;
        syn_valid = 1'b1;
    endtask

    task automatic push(input resp_t r, input logic [TAG_W-1:0] tag, input res_t e);
        logic acc;
        acc = 1'b0;
        drive(r, tag, e);
        for (int i = 0; i < 300; i++) begin
            acc = syn_ready;
            tick();
            if (acc) break;
        end
        chk("push_accepted", 64'(acc), 64'(1));
        syn_valid = 1'b0;
    endtask

    initial begin
        resp_t r;
        logic [TAG_W-1:0] tg;
        int k, e0;
        logic ena2;

        vt[0] = mkv(mkr(8'h12, 8'h34, 8'h56, 8'h78, 5, 8'h01, 8'hA5, 8'h3C, 8'h7E, 8'h09), 3,
                    8'h01, 8'hA5, 8'h3C, 8'h7E, 8'h09, 0, 0, 8);
        vt[1] = mkv(mkr(8'h12, 8'h34, 8'h56, 8'h78, 4, 8'h01, 8'hA5, 8'h3C, 8'h7E, 8'h09), 3,
                    8'h01, 8'hA5, 8'h3C, 8'h7E, 8'h09, 0, 0, 7);
        vt[2] = mkv(mkr(0, 0, 0, 0, 4, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE), 5,
                    0, 0, 0, 0, 0, 1, 0, 2);
        vt[3] = mkv(mkr(0, 0, 0, 8'h01, 0, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99), 9,
                    0, 0, 0, 0, 0, 0, 1, 13);
        vt[4] = mkv(mkr(8'h80, 0, 0, 0, 5, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33), 15,
                    8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 0, 0, 8);
        vt[5] = mkv(mkr(0, 0, 0, 0, 5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 0,
                    0, 0, 0, 0, 0, 1, 0, 2);
        vt[6] = mkv(mkr(0, 0, 8'h09, 0, 4, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50), 6,
                    8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 0, 0, 7);

        // reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_syn_ready", 64'(syn_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_kes_ena", 64'(kes_ena), 64'(0));
        chk("rst_out_data", 64'({out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1,
                                out_tag, out_err_free, out_fail}), 64'(0));

        // directed table; entry 0 runs with kes_done still high from reset
        for (int v = 0; v < 7; v++) begin
            e0   = ena_cnt;
            ena2 = 1'b0;
            drive(vt[v].r, vt[v].tag, vt[v].e);
            tick();
            syn_valid = 1'b0;
            k = 1;
            while (!out_valid && k < 40) begin
                tick();
                k++;
                if (k == 2) ena2 = kes_ena;
            end
            chk($sformatf("tbl%0d_latency", v), 64'(k), 64'(vt[v].k));
            chk($sformatf("tbl%0d_ena_at_c2", v), 64'(ena2), 64'(!vt[v].e.ef));
            tick();
            chk($sformatf("tbl%0d_ena_count", v), 64'(ena_cnt - e0), 64'(!vt[v].e.ef));
            chk($sformatf("tbl%0d_delivered", v), 64'(exp_q.size()), 64'(0));
            chk($sformatf("tbl%0d_out_drop", v), 64'(out_valid), 64'(0));
        end

        // backpressure: FIFO fills behind a stalled result
        out_ready = 1'b0;
        r = mkr(8'h01, 8'h02, 8'h03, 8'h04, 4, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15);
        push(r, 1, model(r, 1));
        r = mkr(8'h05, 8'h06, 8'h07, 8'h08, 5, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25);
        push(r, 2, model(r, 2));
        r = mkr(0, 0, 0, 0, 4, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35);
        push(r, 3, model(r, 3));
        r = mkr(8'h0A, 8'h0B, 8'h0C, 8'h0D, 5, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45);
        drive(r, 4, model(r, 4));
        for (int i = 0; i < 20; i++) begin
            chk("bp_syn_ready_low", 64'(syn_ready), 64'(0));
            tick();
        end
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_first_tag", 64'(out_tag), 64'(1));
        out_ready = 1'b1;
        begin
            logic acc;
            acc = 1'b0;
            for (int i = 0; i < 100 && !acc; i++) begin
                acc = syn_ready;
                tick();
            end
            chk("bp_fourth_accepted", 64'(acc), 64'(1));
        end
        syn_valid = 1'b0;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) tick();
        chk("bp_drained", 64'(exp_q.size()), 64'(0));
        chk("bp_idle", 64'(busy), 64'(0));

        // mid-solve reset with a second set queued
        r = mkr(8'h33, 0, 0, 0, 0, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
        push(r, 7, model(r, 7));
        r = mkr(8'h44, 0, 0, 0, 4, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02);
        push(r, 8, model(r, 8));
        repeat (3) tick();
        chk("mr_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_out_valid", 64'(out_valid), 64'(0));
        chk("mr_syn_ready", 64'(syn_ready), 64'(1));
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_out_data", 64'({out_lambda0, out_lambda1, out_lambda2, out_omega0, out_omega1,
                               out_tag, out_err_free, out_fail}), 64'(0));
        e0 = ena_cnt;
        repeat (6) tick();
        chk("mr_no_relaunch", 64'(ena_cnt - e0), 64'(0));
        chk("mr_still_idle", 64'(out_valid), 64'(0));

        // randomized traffic against the result model
        rand_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            r = '0;
            if ($urandom_range(0, 3) != 0) begin
                r.s0 = 8'($urandom); r.s1 = 8'($urandom);
                r.s2 = 8'($urandom); r.s3 = 8'($urandom);
                if ({r.s0, r.s1, r.s2, r.s3} == 32'd0) r.s2 = 8'h01;
            end
            r.lat = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(4, 5));
            r.l0 = 8'($urandom); r.l1 = 8'($urandom); r.l2 = 8'($urandom);
            r.o0 = 8'($urandom); r.o1 = 8'($urandom);
            tg = TAG_W'($urandom);
            push(r, tg, model(r, tg));
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
        chk("rand_idle", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
